// File: rtl/mbledhesi_seq_param.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock with a registered inter-chunk carry.
// Operands arrive through a valid/ready handshake; result and ALU flags leave through another.
module mbledhesi_seq_param #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int unsigned STEPS = WIDTH / CHUNK;
    localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    if ((WIDTH % CHUNK) != 0 || CHUNK == 0) begin : g_bad_param
        $error("WIDTH must be a non-zero integer multiple of CHUNK");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   a_q, b_q, acc_q;
    logic               carry_q;
    logic [CNT_W-1:0]   step_q;

    logic [IDX_W-1:0]   base;
    logic [CHUNK:0]     chunk_res;
    logic [WIDTH-1:0]   full_sum;
    logic [WIDTH-1:0]   b_eff;
    logic               carry_init;
    logic               last_step;

    always_comb begin
        base      = IDX_W'(32'(step_q) * CHUNK);
        chunk_res = {1'b0, a_q[base +: CHUNK]} + {1'b0, b_q[base +: CHUNK]}
                  + {{CHUNK{1'b0}}, carry_q};
        // Lower chunks of this operation are already in acc_q; splice in the current one.
        full_sum  = acc_q;
        full_sum[base +: CHUNK] = chunk_res[CHUNK-1:0];
        last_step = (step_q == CNT_W'(STEPS - 1));
    end

    always_comb begin
        b_eff = mode[0] ? ~b : b;
        unique case (mode)
            2'b00:   carry_init = 1'b0;
            2'b01:   carry_init = 1'b1;
            default: carry_init = carry_in;
        endcase
    end

    assign in_ready = (state_q == StIdle);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            carry_q   <= 1'b0;
            step_q    <= '0;
            out_valid <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b_eff;
                        carry_q <= carry_init;
                        step_q  <= '0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    acc_q   <= full_sum;
                    carry_q <= chunk_res[CHUNK];
                    if (last_step) begin
                        state_q   <= StDone;
                        out_valid <= 1'b1;
                        sum       <= full_sum;
                        carry_out <= chunk_res[CHUNK];
                        overflow  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                     (full_sum[WIDTH-1] != a_q[WIDTH-1]);
                        zero      <= (full_sum == '0);
                        negative  <= full_sum[WIDTH-1];
                    end else begin
                        step_q <= step_q + 1'b1;
                    end
                end
                StDone: begin
                    // Returning to idle takes a full cycle, so no operand is taken on this edge.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
